// File: rtl/rom_rr_arbiter_if.sv
// Bus between the requesters, the ROM and rom_rr_arbiter.
// The slave modport is the arbiter's view. The master modport is the requester and ROM side.
interface rom_rr_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8
);
    localparam int unsigned IdW = $clog2(NUM_REQ);

    logic                      en;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         rom_address;
    logic [DATA_W-1:0]         rom_data;
    logic                      rsp_valid;
    logic [IdW-1:0]            rsp_id;
    logic [DATA_W-1:0]         rsp_data;

    modport slave (
        input  en, req, req_addr, rom_data,
        output gnt, rom_address, rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output en, req, req_addr, rom_data,
        input  gnt, rom_address, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter that shares one ROM among NUM_REQ requesters and returns tagged read data.
// Defining ROM_ARB_PRIO0_EN gives requester 0 fixed top priority.
module rom_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ROM_LAT = 1
) (
    input logic             clk,
    input logic             rst,
    rom_rr_arbiter_if.slave bus
);
    localparam int unsigned IdW = $clog2(NUM_REQ);

    logic [IdW-1:0]              ptr_q, ptr_d;
    logic [ADDR_W-1:0]           addr_q, addr_d;
    logic [ROM_LAT:0]            tag_v_q, tag_v_d;
    logic [ROM_LAT:0][IdW-1:0]   tag_id_q, tag_id_d;
    logic                        rsp_v_q, rsp_v_d;
    logic [IdW-1:0]              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]           rsp_data_q, rsp_data_d;

    logic                        found;
    logic                        pri0_hit;
    logic [IdW-1:0]              win;
    logic                        accept;
    int unsigned                 idx;

    // Search from ptr upward with wrap. The first requester found wins.
    always_comb begin
        found    = 1'b0;
        pri0_hit = 1'b0;
        win      = '0;
        idx      = 0;
        for (int unsigned o = 0; o < NUM_REQ; o++) begin
            idx = (32'(ptr_q) + o) % NUM_REQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = IdW'(idx);
            end
        end
`ifdef ROM_ARB_PRIO0_EN
        if (bus.req[0]) begin
            found    = 1'b1;
            pri0_hit = 1'b1;
            win      = '0;
        end
`endif
    end

    assign accept  = found & bus.en & ~rst;
    assign bus.gnt = accept ? (NUM_REQ'(1) << win) : '0;

    always_comb begin
        ptr_d  = ptr_q;
        addr_d = addr_q;
        if (accept) begin
            addr_d = bus.req_addr[win*ADDR_W +: ADDR_W];
            if (!pri0_hit) begin
                ptr_d = (32'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
            end
        end
    end

    // The tag pipeline runs in step with the ROM latency, so the last stage lines up with rom_data.
    always_comb begin
        tag_v_d     = '0;
        tag_id_d    = '0;
        tag_v_d[0]  = accept;
        tag_id_d[0] = win;
        for (int i = 1; i <= int'(ROM_LAT); i++) begin
            tag_v_d[i]  = tag_v_q[i-1];
            tag_id_d[i] = tag_id_q[i-1];
        end
    end

    always_comb begin
        rsp_v_d    = tag_v_q[ROM_LAT];
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        if (tag_v_q[ROM_LAT]) begin
            rsp_id_d   = tag_id_q[ROM_LAT];
            rsp_data_d = bus.rom_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            addr_q     <= '0;
            tag_v_q    <= '0;
            tag_id_q   <= '0;
            rsp_v_q    <= 1'b0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            addr_q     <= addr_d;
            tag_v_q    <= tag_v_d;
            tag_id_q   <= tag_id_d;
            rsp_v_q    <= rsp_v_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign bus.rom_address = addr_q;
    assign bus.rsp_valid   = rsp_v_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_data    = rsp_data_q;
endmodule

// File: doc/rom_rr_arbiter.md
Name: rom_rr_arbiter

Overview:
- Shares the single-port lab ROM (8-bit address in, data out) between NUM_REQ independent requesters.
- Performs round-robin arbitration and drives the ROM address.
- Tracks in-flight reads through a ROM_LAT-deep tag pipeline and returns each read's data tagged with the requester ID.
- Sits between the requesting agents and the ROM instance in the lab testbench/top.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 8, ROM address width.
- DATA_W, 8, ROM data width.
- ROM_LAT, 1, cycles from rom_address change to valid rom_data (0 = combinational ROM, max 4).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- en  input  1  arbitration enable; low = no new grants.
- req  input  NUM_REQ  per-requester read request.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- gnt  output  NUM_REQ  one-hot grant (combinational).
- rom_address  output  ADDR_W  registered address to ROM.
- rom_data  input  DATA_W  ROM read data.
- rsp_valid  output  1  response valid, one-cycle pulse per accepted read.
- rsp_id  output  $clog2(NUM_REQ)  requester index of the response.
- rsp_data  output  DATA_W  registered ROM data.

Behaviour:
- Reset (async, rst=1):
  - rom_address=0, rsp_valid=0, rsp_id=0, rsp_data=0.
  - Round-robin pointer ptr=0.
  - Tag pipeline cleared, so all in-flight reads are discarded.
  - gnt=0 while rst=1.
- Handshake: a requester holds req high and req_addr stable until it sees gnt[i]=1. A read is accepted on the rising edge where req[i]&gnt[i]=1. req may then drop or stay high for a back-to-back request.
- Grant logic (combinational):
  - If en=0 or req=0, gnt=0.
  - Otherwise gnt selects the first requesting index searching ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - Exactly one bit is set.
- Pointer update: on an accept by index k, ptr <= (k+1) mod NUM_REQ. Otherwise ptr holds.
- Address: on accept, rom_address <= req_addr of the granted index. Otherwise rom_address holds its last value (ROM re-reads harmlessly).
- Tag pipeline: ROM_LAT+1 stages of {valid,id}. Stage 0 loads {accept,k} at the accept edge; stages shift every cycle.
- Response: at the edge ROM_LAT+1 cycles after the accept edge:
  - rsp_valid<=1, rsp_id<=tag id, rsp_data<=rom_data.
  - Otherwise rsp_valid<=0; rsp_id and rsp_data hold.
- Latency and throughput:
  - Accept edge to rsp_valid high is ROM_LAT+1 cycles (2 for the default).
  - Throughput is one read per cycle, fully pipelined, with no stalls.
  - Response order equals accept order.
- en deasserted mid-stream: no new accepts. Reads already in flight complete normally.
- Single requester continuously high: granted every cycle; ptr cycles back to the same index.
- Reset mid-operation: all in-flight responses are dropped (no rsp_valid after rst releases). First grant after reset goes to the lowest requesting index ≥0.

Optional Feature:
- Macro: ROM_ARB_PRIO0_EN.
- Defined:
  - Requester 0 has fixed top priority. Whenever req[0]=1 and en=1, gnt=...0001.
  - Grants to index 0 do not update ptr.
  - Round-robin among indices 1..NUM_REQ-1 continues from ptr when req[0]=0.
- Undefined: pure round-robin as above. No port differences.

Test Plan:
- Reset/idle: rst=1 for 3 cycles with req=4'b1111 → gnt=0, rsp_valid=0, rom_address=0. Release rst with req=0 → outputs stay 0.
- Single read: ROM_LAT=1, ROM[0x12]=0xA5, req[2]=1 with addr 0x12 → gnt=4'b0100 that cycle; rom_address=0x12 next cycle; rsp_valid=1, rsp_id=2, rsp_data=0xA5 exactly 2 cycles after accept.
- Round-robin fairness: req=4'b1111 held, addresses 0x00/0x01/0x02/0x03 → grant order 0,1,2,3,0,…; rsp_id sequence 0,1,2,3 on consecutive cycles with matching data.
- Wrap and skip: ptr=3 (after granting 2), req=4'b0011 → next grants 0 then 1. With req=4'b1000 only → grant 3 each cycle.
- en and reset mid-flight: 4 back-to-back accepts, then en=0 → 4 responses still delivered and no new gnt. Repeat, asserting rst one cycle after the 2nd accept → no rsp_valid after reset release.
- ROM_ARB_PRIO0_EN defined: req=4'b1110 then req[0] raised on cycle 2 → grant 1, then 0 on cycle 2 while req[0]=1, then 2 resumes when req[0] drops.
